snoopy_bus_arbiter: RTL
=======================

SNOOPY_BUS_ARBITER -- requirements
Module: snoopy_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_CACHES, default 8, giving the number of caches sharing the snoopy bus.
REQ-002 The block SHALL have parameter CACHE_NUMBER_WIDTH, default $clog2(NUMBER_OF_CACHES), giving the owner index width.
REQ-003 Port: clock  input  1  single clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: request  input  NUMBER_OF_CACHES  per-cache bus request; held high for the whole tenure.
REQ-006 Port: commandValid  input  1  owner broadcasting a bus command (read/invalidate).
REQ-007 Port: snoopAcknowledge  input  NUMBER_OF_CACHES  per-cache "snoop finished" level.
REQ-008 Port: grant  output  NUMBER_OF_CACHES  one-hot bus grant; all-zero when the bus is free.
REQ-009 Port: ownerNumber  output  CACHE_NUMBER_WIDTH  binary index of the current owner; 0 when the bus is free.
REQ-010 Port: busBusy  output  1  high whenever grant is non-zero.
REQ-011 Port: commandDone  output  1  one-cycle pulse: all non-owner caches have acknowledged the current command.

Function
REQ-012 The FSM SHALL have states IDLE, GRANTED and SNOOP; all outputs SHALL be registered.
REQ-013 In IDLE with request != 0, the block SHALL select the first requester in round-robin order, starting at (lastOwner+1) mod NUMBER_OF_CACHES.
REQ-014 The block SHALL raise grant, ownerNumber and busBusy on the next edge and enter GRANTED (one-cycle request-to-grant latency).
REQ-015 In IDLE with request == 0, the block SHALL keep grant at 0 and hold lastOwner unchanged.
REQ-016 In GRANTED, if request[owner] is 0, the block SHALL clear grant/ownerNumber/busBusy on the next edge, set lastOwner = owner and return to IDLE.
REQ-017 Release followed by a new grant SHALL therefore cost exactly one idle cycle (grant == 0).
REQ-018 In GRANTED with commandValid high and request[owner] high, the block SHALL enter SNOOP.
REQ-019 If commandValid and a dropped request[owner] coincide, the release rule SHALL win and commandValid SHALL be ignored.
REQ-020 In SNOOP, the acknowledge condition SHALL be (snoopAcknowledge | grant) == all ones; the owner's own acknowledge bit is don't-care.
REQ-021 When the acknowledge condition holds in SNOOP, the block SHALL pulse commandDone for exactly one cycle on the next edge and return to GRANTED.
REQ-022 A command SHALL produce exactly one commandDone pulse.
REQ-023 The owner deasserting request during SNOOP SHALL be ignored until commandDone has pulsed. The GRANTED release rule then applies on the following cycle.
REQ-024 Requests from non-owners SHALL never preempt the owner. The grant changes only through IDLE.
REQ-025 The round-robin wrap SHALL be modulo NUMBER_OF_CACHES: after the owner NUMBER_OF_CACHES-1, the search SHALL start at 0.
REQ-026 grant SHALL always be one-hot or zero, and ownerNumber SHALL always equal the index of the set grant bit.
REQ-027 With NUMBER_OF_CACHES == 1 the block SHALL still work: the acknowledge condition is immediately true, so commandDone pulses one cycle after entering SNOOP.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set state = IDLE, grant = 0, ownerNumber = 0, busBusy = 0, commandDone = 0 and lastOwner = NUMBER_OF_CACHES-1, so that cache 0 has first priority.
REQ-029 Reset asserted mid-tenure or mid-SNOOP SHALL abort the tenure. No commandDone SHALL be issued for the aborted command.
REQ-030 After reset deasserts, arbitration SHALL restart per REQ-013.

Verification
REQ-031 After reset, request=8'b0000_0101 -> next cycle grant=8'b0000_0001, ownerNumber=0, busBusy=1.
REQ-032 Cache 0 then drops its request while request[2] stays high -> one cycle grant=0, then grant=8'b0000_0100, ownerNumber=2.
REQ-033 Owner 2 holds commandValid; snoopAcknowledge goes to 8'b1111_1011 three cycles later -> exactly one commandDone pulse one cycle after the full ack, then state GRANTED.
REQ-034 lastOwner=7 and request=8'b1000_0010 -> grant=8'b0000_0010 (wrap-around).
REQ-035 Owner drops request during SNOOP and acks complete -> commandDone pulses, then grant=0 on the following cycle.
REQ-036 Reset pulsed while in SNOOP with owner 5 -> grant=0, no commandDone; with request=8'hFF afterwards -> grant=8'b0000_0001.

Source files
------------

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin arbiter for a snoopy bus. Caches request tenure, the owner may
// broadcast commands, and commandDone pulses once every other cache has acknowledged.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | bus free, grant = 0, choose the next requester after lastOwner
// GRANTED | owner holds the bus, waiting for release or commandValid
// SNOOP   | command broadcast, waiting for all non-owner acknowledges
module snoopy_bus_arbiter #(
  parameter int NUMBER_OF_CACHES   = 8,
  parameter int CACHE_NUMBER_WIDTH = $clog2(NUMBER_OF_CACHES)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUMBER_OF_CACHES-1:0]   request,
  input  logic                          commandValid,
  input  logic [NUMBER_OF_CACHES-1:0]   snoopAcknowledge,
  output logic [NUMBER_OF_CACHES-1:0]   grant,
  output logic [CACHE_NUMBER_WIDTH-1:0] ownerNumber,
  output logic                          busBusy,
  output logic                          commandDone
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    SNOOP   = 2'd2
  } stateType;

  stateType                        state;
  stateType                        nextState;
  logic [CACHE_NUMBER_WIDTH-1:0]   lastOwner;
  logic [CACHE_NUMBER_WIDTH-1:0]   nextLastOwner;
  logic [NUMBER_OF_CACHES-1:0]     nextGrant;
  logic [CACHE_NUMBER_WIDTH-1:0]   nextOwnerNumber;
  logic                            nextBusBusy;
  logic                            nextCommandDone;

  logic                            pickValid;
  logic [CACHE_NUMBER_WIDTH-1:0]   pickIndex;
  logic [CACHE_NUMBER_WIDTH-1:0]   candidate;
  logic                            ownerRequest;
  logic                            acksComplete;

  // Search order starts just after the previous owner and wraps modulo the cache count.
  always_comb begin
    pickValid = 1'b0;
    pickIndex = '0;
    candidate = '0;
    for (int offset = 1; offset <= NUMBER_OF_CACHES; offset++) begin
      candidate = CACHE_NUMBER_WIDTH'((int'(lastOwner) + offset) % NUMBER_OF_CACHES);
      if (!pickValid && request[candidate]) begin
        pickValid = 1'b1;
        pickIndex = candidate;
      end
    end
  end

  assign ownerRequest = request[ownerNumber];
  // The owner's grant bit stands in for its own acknowledge.
  assign acksComplete = &(snoopAcknowledge | grant);

  always_comb begin
    nextState       = state;
    nextGrant       = grant;
    nextOwnerNumber = ownerNumber;
    nextBusBusy     = busBusy;
    nextCommandDone = 1'b0;
    nextLastOwner   = lastOwner;
    unique case (state)
      IDLE: begin
        if (pickValid) begin
          nextState            = GRANTED;
          nextGrant            = '0;
          nextGrant[pickIndex] = 1'b1;
          nextOwnerNumber      = pickIndex;
          nextBusBusy          = 1'b1;
        end
      end
      GRANTED: begin
        // Release takes priority over a coincident command.
        if (!ownerRequest) begin
          nextState       = IDLE;
          nextGrant       = '0;
          nextOwnerNumber = '0;
          nextBusBusy     = 1'b0;
          nextLastOwner   = ownerNumber;
        end else if (commandValid) begin
          nextState = SNOOP;
        end
      end
      SNOOP: begin
        if (acksComplete) begin
          nextCommandDone = 1'b1;
          nextState       = GRANTED;
        end
      end
      default: begin
        nextState       = IDLE;
        nextGrant       = '0;
        nextOwnerNumber = '0;
        nextBusBusy     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      ownerNumber <= '0;
      busBusy     <= 1'b0;
      commandDone <= 1'b0;
      lastOwner   <= CACHE_NUMBER_WIDTH'(NUMBER_OF_CACHES - 1);
    end else begin
      state       <= nextState;
      grant       <= nextGrant;
      ownerNumber <= nextOwnerNumber;
      busBusy     <= nextBusBusy;
      commandDone <= nextCommandDone;
      lastOwner   <= nextLastOwner;
    end
  end

`ifndef SYNTHESIS
  grantOneHot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant));
  busyMatchesGrant: assert property (@(posedge clock) disable iff (reset) busBusy == (grant != '0));
  ownerMatchesGrant: assert property (@(posedge clock) disable iff (reset)
    (grant == '0) ? (ownerNumber == '0) : grant[ownerNumber]);
`endif

endmodule
